warmboot_ctrl: RTL and testbench
================================

# warmboot_ctrl

Clocked controller for the iCE40 `SB_WARMBOOT` hard core. It selects one of up to four stored bitstream images from a user push-button or from an on-chip requester, then sequences the hard core safely. The S1/S0 select lines are registered and held stable for a programmable setup time before BOOT is asserted, and BOOT is then held until the device reconfigures. The block sits between the board buttons / command logic and a single `SB_WARMBOOT` instance that it drives directly.

## Interface
- `DEBOUNCE_CYCLES`, default 120000: consecutive stable samples needed to accept a button level (10 ms at 12 MHz).
- `SETUP_CYCLES`, default 16: cycles S1/S0 are held stable before BOOT rises; minimum 1.
- `NUM_IMAGES`, default 4: number of valid images; legal range 1..4.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_next`  in  1  raw button, active-high, asynchronous; advances the image.
- `btn_boot`  in  1  raw button, active-high, asynchronous; boots the current image.
- `req_valid`  in  1  on-chip boot request.
- `req_image`  in  2  image requested with `req_valid`.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_err`  out  1  one-cycle pulse when an accepted request holds an out-of-range image.
- `image`  out  2  currently selected image, for display.
- `busy`  out  1  high whenever the state is not IDLE.
- `wb_s`  out  2  drives `SB_WARMBOOT` S1/S0; registered.
- `wb_boot`  out  1  drives `SB_WARMBOOT` BOOT; registered.

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive samples that differ from it.
  - A rising edge of the debounced level produces a one-cycle pulse (`next_p`, `boot_p`).
- FSM states:
  - IDLE to SETUP on a boot event.
  - SETUP to FIRE after `SETUP_CYCLES`.
  - FIRE is terminal; only reset leaves it.
- Events in IDLE, in priority order:
  1. `req_valid` with `req_image < NUM_IMAGES`: `image <= req_image`, go to SETUP.
  2. `req_valid` with `req_image >= NUM_IMAGES`: request is accepted, `req_err` pulses, `image` is unchanged, stay in IDLE.
  3. `boot_p`: go to SETUP with the current `image`.
  4. `next_p`: `image <= (image == NUM_IMAGES-1) ? 0 : image+1`.
- Lower-priority events in the same cycle are discarded, not queued. For example, `next_p` together with `boot_p` boots the un-incremented image.
- `req_ready = (state == IDLE)`.
- Outside IDLE, `req_valid`, `next_p` and `boot_p` are ignored.
- `wb_s` is a register loaded from `image` in every cycle while in IDLE. It is frozen on the IDLE-to-SETUP transition with the booted image and does not change afterwards.
- SETUP loads a down-counter with `SETUP_CYCLES-1` and leaves for FIRE at zero.
- In FIRE, `wb_boot` is 1 and held.
- Counter widths: debounce counter `$clog2(DEBOUNCE_CYCLES+1)` bits; setup counter `$clog2(SETUP_CYCLES+1)` bits. The image counter is 2 bits and wraps explicitly; it never relies on overflow unless `NUM_IMAGES == 4`.

## Timing
- Reset values: `image=0`, `wb_s=0`, `wb_boot=0`, `req_err=0`, `busy=0`, `req_ready=1`, state IDLE, debounced levels 0, all counters 0.
- Button latency: raw edge to `*_p` takes 2 sync cycles + `DEBOUNCE_CYCLES` (±1 sample).
- Boot event accepted in cycle N:
  - `busy=1` and `wb_s` final at N+1.
  - `wb_boot` rises at N+1+`SETUP_CYCLES`.
- Request handshake completes in the cycle `req_valid && req_ready`. `image` updates at N+1. `req_err` is high during N+1 only.
- Reset asserted mid-SETUP or mid-FIRE: everything returns to reset values immediately (asynchronous) and no BOOT pulse is produced. Release is synchronous to `clk` through the normal flops.
- `wb_s` never changes while `wb_boot=1` or during SETUP.

## Structure
- Package `warmboot_pkg`:
  - state enum `wb_state_t` {IDLE, SETUP, FIRE};
  - `WB_IMG_W = 2`;
  - `WB_MAX_IMAGES = 4`.
- Sub-module `wb_debounce`:
  - contains the synchronizer, debounce counter and rising-edge pulse;
  - parameter `DEBOUNCE_CYCLES`;
  - ports `clk`, `rst_n`, `raw`, `level`, `rise`;
  - instanced twice.
- The top level holds the FSM, the image register and the setup counter. `SB_WARMBOOT` is instanced by the board top, not here.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `SETUP_CYCLES=3`.
- Pulse `btn_next` 5 times, each held 10 cycles, with `NUM_IMAGES=4` → `image` goes 1,2,3,0,1; `wb_s` follows one cycle later; `busy` stays 0.
- Bounce `btn_next` 1-0-1-0 with 2-cycle toggles, then hold 0 → `image` unchanged.
- `image=2`, press `btn_boot` → `busy` rises and `wb_s=2`; `wb_boot=1` exactly 3 cycles later and held; further `btn_next` or requests are ignored and `req_ready=0`.
- `req_valid` with `req_image=3`, `NUM_IMAGES=3` → handshake in one cycle, `req_err` pulse, state stays IDLE; then `req_image=1` → `image=1`, `wb_boot` rises 4 cycles after the accept.
- `req_valid` (image 1) coincident with `boot_p` (`image=0`) → boots image 1. `next_p` coincident with `boot_p` → boots the un-incremented image.
- Assert `rst_n=0` during SETUP → `wb_boot` never rises, all outputs return to reset values, `req_ready=1`.

Source files
------------

// File: rtl/warmboot_pkg.sv
// Shared types and limits for the SB_WARMBOOT sequencing controller.
package warmboot_pkg;
  localparam int WB_IMG_W      = 2;
  localparam int WB_MAX_IMAGES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2
  } wb_state_t;
endpackage

// File: rtl/wb_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and rising-edge pulse
// for one raw push-button.
module wb_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, count consecutive differing samples, flip level and pulse on rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      rise_r  <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        // the DEBOUNCE_CYCLES-th differing sample is being taken now
        level_r <= sync2_r;
        rise_r  <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
endmodule

// File: rtl/warmboot_ctrl.sv
// Image selection and safe S1/S0 -> BOOT sequencing for the SB_WARMBOOT core.
// wb_s is frozen once a boot is taken; FIRE is left only through reset.
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SETUP_CYCLES    = 16,
  parameter int NUM_IMAGES      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_next,
  input  logic                btn_boot,
  input  logic                req_valid,
  input  logic [WB_IMG_W-1:0] req_image,
  output logic                req_ready,
  output logic                req_err,
  output logic [WB_IMG_W-1:0] image,
  output logic                busy,
  output logic [WB_IMG_W-1:0] wb_s,
  output logic                wb_boot
);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam logic [SW-1:0]       SETUP_LOAD = SW'(SETUP_CYCLES - 1);
  localparam logic [WB_IMG_W-1:0] LAST_IMG   = WB_IMG_W'(NUM_IMAGES - 1);
  localparam logic [WB_IMG_W:0]   NUM_IMG_X  = (WB_IMG_W + 1)'(NUM_IMAGES);

  wb_state_t           state_r;
  logic [WB_IMG_W-1:0] image_r;
  logic [WB_IMG_W-1:0] wb_s_r;
  logic                wb_boot_r;
  logic                req_err_r;
  logic                busy_r;
  logic                req_ready_r;
  logic [SW-1:0]       setup_cnt_r;

  logic                next_p_s;
  logic                boot_p_s;
  logic                next_lvl_s;
  logic                boot_lvl_s;
  logic                unused_lvl_s;
  logic                req_ok_s;
  logic [WB_IMG_W-1:0] image_inc_s;

  wb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_next),
    .level (next_lvl_s),
    .rise  (next_p_s)
  );

  wb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_boot (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_boot),
    .level (boot_lvl_s),
    .rise  (boot_p_s)
  );

  assign unused_lvl_s = next_lvl_s & boot_lvl_s;
  assign req_ok_s     = ({1'b0, req_image} < NUM_IMG_X);
  assign image_inc_s  = (image_r == LAST_IMG) ? {WB_IMG_W{1'b0}} : image_r + WB_IMG_W'(1);

  // Boot sequencer: prioritised IDLE events, setup countdown, terminal FIRE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      image_r     <= {WB_IMG_W{1'b0}};
      wb_s_r      <= {WB_IMG_W{1'b0}};
      wb_boot_r   <= 1'b0;
      req_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      req_ready_r <= 1'b1;
      setup_cnt_r <= {SW{1'b0}};
    end else begin
      req_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          wb_s_r <= image_r;
          if (req_valid && req_ok_s) begin
            image_r     <= req_image;
            wb_s_r      <= req_image;
            state_r     <= SETUP;
            setup_cnt_r <= SETUP_LOAD;
            busy_r      <= 1'b1;
            req_ready_r <= 1'b0;
          end else if (req_valid) begin
            req_err_r <= 1'b1;
          end else if (boot_p_s) begin
            state_r     <= SETUP;
            setup_cnt_r <= SETUP_LOAD;
            busy_r      <= 1'b1;
            req_ready_r <= 1'b0;
          end else if (next_p_s) begin
            image_r <= image_inc_s;
          end else begin
            image_r <= image_r;
          end
        end
        SETUP: begin
          if (setup_cnt_r == {SW{1'b0}}) begin
            state_r   <= FIRE;
            wb_boot_r <= 1'b1;
          end else begin
            setup_cnt_r <= setup_cnt_r - SW'(1);
          end
        end
        FIRE: begin
          wb_boot_r <= 1'b1;
        end
        default: begin
          // unreachable encoding: fall back to a quiet IDLE without booting
          state_r     <= IDLE;
          wb_boot_r   <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign req_err   = req_err_r;
  assign image     = image_r;
  assign busy      = busy_r;
  assign wb_s      = wb_s_r;
  assign wb_boot   = wb_boot_r;
endmodule

// File: tb/tb_warmboot_ctrl.sv
// Self-checking bench: two controllers (4 and 3 images) against a small
// behavioural model of the selected image and the boot timing rules.
module tb_warmboot_ctrl;
  localparam int D   = 4;
  localparam int S   = 3;
  localparam int LAT = 2 + D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bn = 2'b00;
  logic [1:0] bb = 2'b00;
  logic [1:0] rv = 2'b00;
  logic [1:0] ri  [2];
  logic [1:0] img [2];
  logic [1:0] ws  [2];
  logic [1:0] wbb, bsy, rdy, err;

  int errors = 0;
  int checks = 0;
  int nimg  [2];
  int m_img [2];

  always #5 clk = ~clk;

  warmboot_ctrl #(.DEBOUNCE_CYCLES(D), .SETUP_CYCLES(S), .NUM_IMAGES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .btn_next(bn[0]), .btn_boot(bb[0]),
    .req_valid(rv[0]), .req_image(ri[0]), .req_ready(rdy[0]), .req_err(err[0]),
    .image(img[0]), .busy(bsy[0]), .wb_s(ws[0]), .wb_boot(wbb[0]));

  warmboot_ctrl #(.DEBOUNCE_CYCLES(D), .SETUP_CYCLES(S), .NUM_IMAGES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .btn_next(bn[1]), .btn_boot(bb[1]),
    .req_valid(rv[1]), .req_image(ri[1]), .req_ready(rdy[1]), .req_err(err[1]),
    .image(img[1]), .busy(bsy[1]), .wb_s(ws[1]), .wb_boot(wbb[1]));

  function automatic logic [7:0] obs(int k);
    return {img[k], ws[k], wbb[k], bsy[k], rdy[k], err[k]};
  endfunction

  // quiet IDLE with image im: {image, wb_s, wb_boot, busy, req_ready, req_err}
  function automatic logic [7:0] idle_exp(int im);
    logic [1:0] v;
    v = im[1:0];
    return {v, v, 4'b0010};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bn = 2'b00; bb = 2'b00; rv = 2'b00;
    ri[0] = 2'd0; ri[1] = 2'd0;
    m_img[0] = 0; m_img[1] = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic press_next(int k, int hold);
    bn[k] = 1'b1;
    repeat (hold) step();
    bn[k] = 1'b0;
    repeat (10) step();
    m_img[k] = (m_img[k] + 1) % nimg[k];
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== idle_exp(0)) begin
        errors++;
        $display("FAIL reset[%0d] got %b exp %b", k, obs(k), idle_exp(0));
      end
    end
  endtask

  task automatic test_next_wrap();
    int old, seen;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      old = m_img[0];
      m_img[0] = (m_img[0] + 1) % nimg[0];
      bn[0] = 1'b1;
      seen = -1;
      for (int c = 0; c < 30 && seen < 0; c++) begin
        step();
        if (img[0] !== old[1:0]) seen = c;
      end
      checks++;
      if (seen < 0 || img[0] !== m_img[0][1:0] || ws[0] !== old[1:0]) begin
        errors++;
        $display("FAIL next_step[%0d] image=%0d wb_s=%0d exp image=%0d wb_s=%0d", i, img[0], ws[0], m_img[0], old);
      end
      step();
      checks++;
      if (ws[0] !== m_img[0][1:0] || bsy[0] !== 1'b0) begin
        errors++;
        $display("FAIL next_lag[%0d] wb_s=%0d busy=%0d exp wb_s=%0d busy=0", i, ws[0], bsy[0], m_img[0]);
      end
      repeat (2) step();
      bn[0] = 1'b0;
      repeat (10) step();
      checks++;
      if (obs(0) !== idle_exp(m_img[0])) begin
        errors++;
        $display("FAIL next_idle[%0d] got %b exp %b", i, obs(0), idle_exp(m_img[0]));
      end
    end
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 4; t++) begin
      bn[0] = (t % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) step();
    end
    bn[0] = 1'b0;
    repeat (15) step();
    checks++;
    if (obs(0) !== idle_exp(m_img[0])) begin
      errors++;
      $display("FAIL bounce got %b exp %b", obs(0), idle_exp(m_img[0]));
    end
  endtask

  task automatic test_button_boot();
    int n;
    apply_reset();
    press_next(0, 10);
    press_next(0, 10);
    bb[0] = 1'b1;
    n = 0;
    while (bsy[0] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n < LAT || n > LAT + 2 || ws[0] !== 2'd2 || wbb[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL boot_start lat=%0d wb_s=%0d wb_boot=%0d req_ready=%0d exp lat %0d..%0d wb_s=2 wb_boot=0 req_ready=0",
               n, ws[0], wbb[0], rdy[0], LAT, LAT + 2);
    end
    for (int j = 1; j <= S; j++) begin
      step();
      checks++;
      if (wbb[0] !== ((j == S) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL boot_delay[%0d] wb_boot=%0d exp %0d", j, wbb[0], (j == S));
      end
    end
    bb[0] = 1'b0;
    bn[0] = 1'b1; rv[0] = 1'b1; ri[0] = 2'd0;
    repeat (12) step();
    bn[0] = 1'b0; rv[0] = 1'b0;
    repeat (3) step();
    checks++;
    if (obs(0) !== {2'd2, 2'd2, 4'b1100}) begin
      errors++;
      $display("FAIL boot_hold got %b exp %b", obs(0), {2'd2, 2'd2, 4'b1100});
    end
  endtask

  task automatic test_req_err();
    apply_reset();
    ri[1] = 2'd3; rv[1] = 1'b1;
    checks++;
    if (rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle got %0d exp 1", rdy[1]);
    end
    step();
    rv[1] = 1'b0;
    checks++;
    if (obs(1) !== {2'd0, 2'd0, 4'b0011}) begin
      errors++;
      $display("FAIL req_err_pulse got %b exp %b", obs(1), {2'd0, 2'd0, 4'b0011});
    end
    step();
    checks++;
    if (obs(1) !== idle_exp(0)) begin
      errors++;
      $display("FAIL req_err_clear got %b exp %b", obs(1), idle_exp(0));
    end
    ri[1] = 2'd1; rv[1] = 1'b1;
    step();
    rv[1] = 1'b0;
    checks++;
    if (obs(1) !== {2'd1, 2'd1, 4'b0100}) begin
      errors++;
      $display("FAIL req_accept got %b exp %b", obs(1), {2'd1, 2'd1, 4'b0100});
    end
    for (int k = 2; k <= S + 1; k++) begin
      step();
      checks++;
      if (wbb[1] !== ((k == S + 1) ? 1'b1 : 1'b0) || ws[1] !== 2'd1) begin
        errors++;
        $display("FAIL req_fire[%0d] wb_boot=%0d wb_s=%0d exp wb_boot=%0d wb_s=1", k, wbb[1], ws[1], (k == S + 1));
      end
    end
  endtask

  task automatic test_coincide();
    int n;
    apply_reset();
    bb[0] = 1'b1;
    repeat (LAT) step();
    rv[0] = 1'b1; ri[0] = 2'd1;
    step();
    rv[0] = 1'b0;
    checks++;
    if (img[0] !== 2'd1 || ws[0] !== 2'd1 || bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL req_vs_boot image=%0d wb_s=%0d busy=%0d exp 1 1 1", img[0], ws[0], bsy[0]);
    end
    bb[0] = 1'b0;
    repeat (S + 2) step();
    checks++;
    if (obs(0) !== {2'd1, 2'd1, 4'b1100}) begin
      errors++;
      $display("FAIL req_vs_boot_fire got %b exp %b", obs(0), {2'd1, 2'd1, 4'b1100});
    end
    apply_reset();
    press_next(0, 10);
    bn[0] = 1'b1; bb[0] = 1'b1;
    n = 0;
    while (bsy[0] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n >= 30 || img[0] !== m_img[0][1:0] || ws[0] !== m_img[0][1:0]) begin
      errors++;
      $display("FAIL next_vs_boot image=%0d wb_s=%0d exp %0d", img[0], ws[0], m_img[0]);
    end
    bn[0] = 1'b0; bb[0] = 1'b0;
  endtask

  task automatic test_reset_mid_setup();
    int bad;
    apply_reset();
    rv[0] = 1'b1; ri[0] = 2'd2;
    step();
    rv[0] = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs(0) !== idle_exp(0)) begin
      errors++;
      $display("FAIL reset_async got %b exp %b", obs(0), idle_exp(0));
    end
    repeat (3) step();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (obs(0) !== idle_exp(0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_boot bad_cycles=%0d exp 0 last %b", bad, obs(0));
    end
  endtask

  task automatic test_random();
    int k, act;
    apply_reset();
    for (int it = 0; it < 24; it++) begin
      k = $urandom_range(0, 1);
      act = $urandom_range(0, 2);
      if (act == 0) begin
        press_next(k, $urandom_range(D + 3, 12));
      end else if (act == 1) begin
        bn[k] = 1'b1;
        repeat ($urandom_range(1, D - 1)) step();
        bn[k] = 1'b0;
        repeat (8) step();
      end else if (k == 1) begin
        ri[1] = 2'd3; rv[1] = 1'b1;
        step();
        rv[1] = 1'b0;
        checks++;
        if (err[1] !== 1'b1 || img[1] !== m_img[1][1:0]) begin
          errors++;
          $display("FAIL rand_err[%0d] req_err=%0d image=%0d exp 1 %0d", it, err[1], img[1], m_img[1]);
        end
        repeat (2) step();
      end else begin
        bb[0] = 1'b1;
        repeat ($urandom_range(1, D - 1)) step();
        bb[0] = 1'b0;
        repeat (8) step();
      end
      for (int q = 0; q < 2; q++) begin
        checks++;
        if (obs(q) !== idle_exp(m_img[q])) begin
          errors++;
          $display("FAIL rand[%0d][%0d] got %b exp %b", it, q, obs(q), idle_exp(m_img[q]));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nimg[0] = 4;
    nimg[1] = 3;
    test_reset();
    test_next_wrap();
    test_bounce();
    test_button_boot();
    test_req_err();
    test_coincide();
    test_reset_mid_setup();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
